// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle data-memory access unit. Takes the ALU byte address, rs2
//   store data and func_3 from the core, performs one handshaked memory
//   access, and returns the extended load result or a fault. stall freezes
//   the PC from the accept cycle until the response cycle.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_*               core request: valid, store, func_3, address, data
//   req_ready           unit is idle and can accept a request
//   rsp_valid           one-cycle completion pulse
//   rsp_load_data       extended load data (0 on stores and faults)
//   rsp_fault           misaligned access or illegal func_3
//   stall               hold PC / register write while the access runs
//   mem_*               data-memory request (valid/ready) and read return
//                       (rvalid with read data)
//   debug_state         current FSM state (IDLE=0, REQ=1, WAIT_LOAD=2, RESP=3)
//
// Handshakes
//   Core side: a request is taken on a rising edge where req_valid=1 and
//   req_ready=1; req_ready is 1 only in IDLE. Memory side: the request is
//   taken on a rising edge where mem_valid=1 and mem_ready=1, and mem_* stay
//   constant until then; read data is taken on the first edge with
//   mem_rvalid=1 in WAIT_LOAD. mem_ready/mem_rvalid in other states are ignored.

module load_store_unit #(
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic                      req_store,
  input  logic [2:0]                req_func_3,
  input  logic [31:0]               req_address,
  input  logic [31:0]               req_store_data,
  output logic                      req_ready,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_load_data,
  output logic                      rsp_fault,
  output logic                      stall,
  output logic                      mem_valid,
  output logic                      mem_write,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]                mem_byte_enable,
  output logic [31:0]               mem_write_data,
  input  logic                      mem_ready,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_read_data,
  output logic [1:0]                debug_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_LOAD = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched request
  logic                      store_q;
  logic [2:0]                func_q;
  logic [MEM_ADDR_WIDTH+1:0] addr_q;
  logic [31:0]               data_q;
  logic                      fault_q;
  logic [31:0]               load_data_q;

  // Address bits above the memory window are not used by the access.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_address[31:MEM_ADDR_WIDTH+2];

  // Fault decode on the incoming request. Stores only allow B/H/W;
  // unsigned variants are load-only.
  logic req_fault;
  always_comb begin
    req_fault = 1'b0;
    case (req_func_3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = req_address[0];
      3'b010:  req_fault = (req_address[1:0] != 2'b00);
      3'b100:  req_fault = req_store;
      3'b101:  req_fault = req_store | req_address[0];
      default: req_fault = 1'b1;
    endcase
  end

  // Lane enables and replicated store data from latched values.
  logic [3:0]  be;
  logic [31:0] wdata;
  always_comb begin
    be    = 4'b1111;
    wdata = data_q;
    case (func_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{data_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = data_q;
      end
    endcase
  end

  // Load lane extraction and extension.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  always_comb begin
    byte_sel = mem_read_data[7:0];
    case (addr_q[1:0])
      2'b00: byte_sel = mem_read_data[7:0];
      2'b01: byte_sel = mem_read_data[15:8];
      2'b10: byte_sel = mem_read_data[23:16];
      2'b11: byte_sel = mem_read_data[31:24];
      default: byte_sel = mem_read_data[7:0];
    endcase
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (func_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_read_data;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      store_q     <= 1'b0;
      func_q      <= 3'd0;
      addr_q      <= '0;
      data_q      <= 32'd0;
      fault_q     <= 1'b0;
      load_data_q <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        store_q     <= req_store;
        func_q      <= req_func_3;
        addr_q      <= req_address[MEM_ADDR_WIDTH+1:0];
        data_q      <= req_store_data;
        fault_q     <= req_fault;
        // Cleared here so stores and faults respond with zero data.
        load_data_q <= 32'd0;
      end
      if (state == WAIT_LOAD && mem_rvalid) begin
        load_data_q <= load_ext;
      end
    end
  end

  // Next state and outputs
  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_fault       = 1'b0;
    rsp_load_data   = 32'd0;
    stall           = 1'b0;
    mem_valid       = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_byte_enable = 4'd0;
    mem_write_data  = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) state_next = req_fault ? RESP : REQ;
      end
      REQ: begin
        stall           = 1'b1;
        mem_valid       = 1'b1;
        mem_write       = store_q;
        mem_address     = addr_q[MEM_ADDR_WIDTH+1:2];
        mem_byte_enable = be;
        mem_write_data  = store_q ? wdata : 32'd0;
        if (mem_ready) state_next = store_q ? RESP : WAIT_LOAD;
      end
      WAIT_LOAD: begin
        stall = 1'b1;
        if (mem_rvalid) state_next = RESP;
      end
      RESP: begin
        rsp_valid     = 1'b1;
        rsp_fault     = fault_q;
        rsp_load_data = load_data_q;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign debug_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid, req_store;
  logic [2:0]    req_func_3;
  logic [31:0]   req_address, req_store_data;
  logic          req_ready, rsp_valid, rsp_fault, stall;
  logic [31:0]   rsp_load_data;
  logic          mem_valid, mem_write, mem_ready, mem_rvalid;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byte_enable;
  logic [31:0]   mem_write_data, mem_read_data;
  logic [1:0]    debug_state;

  load_store_unit #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_store(req_store), .req_func_3(req_func_3),
    .req_address(req_address), .req_store_data(req_store_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_load_data(rsp_load_data),
    .rsp_fault(rsp_fault), .stall(stall),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_read_data(mem_read_data),
    .debug_state(debug_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;

  // {fault, load_data[31:0], expected response cycle[31:0]}
  logic [64:0] exp_q[$];
  // {write, word address[11:0], byte enables[3:0], write data[31:0]}
  logic [48:0] mem_q[$];
  int          w_q[$];
  int          r_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-addressed view of the 8-word memory window (byte address bits [4:0]).
  logic [7:0]  ref_bytes[32];
  logic [31:0] mem_words[8];

  function automatic int size_of(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_fault(input logic st, input logic [2:0] f, input logic [31:0] a);
    logic legal;
    legal = st ? (f inside {3'b000, 3'b001, 3'b010})
               : (f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (!legal) return 1'b1;
    return (int'(a[1:0]) % size_of(f)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    logic [63:0] v;
    int sz, base;
    sz = size_of(f);
    base = int'(a[4:0]);
    v = 64'd0;
    for (int k = 0; k < sz; k++) v = v | (64'(ref_bytes[base + k]) << (8 * k));
    if (!f[2] && sz < 4 && v[8 * sz - 1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int sz, base;
    sz = size_of(f);
    base = int'(a[4:0]);
    for (int k = 0; k < sz; k++) ref_bytes[base + k] = d[8 * k +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input int w, input int r);
    int guard;
    logic flt;
    logic [31:0] exp_data, exp_wdata;
    logic [3:0] exp_be;
    int sz, lat;
    guard = 0;
    // While busy, wiggle the request inputs: nothing may be accepted.
    while (!req_ready) begin
      req_valid = 1'($urandom_range(0, 1));
      req_store = 1'($urandom_range(0, 1));
      req_func_3 = 3'($urandom_range(0, 7));
      req_address = $urandom;
      req_store_data = $urandom;
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        check("req_ready_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        return;
      end
    end
    flt = model_fault(st, f, a);
    sz = size_of(f);
    exp_be = 4'(((1 << sz) - 1) << a[1:0]);
    for (int k = 0; k < 4; k++) exp_wdata[8 * k +: 8] = d[8 * (k % sz) +: 8];
    exp_data = 32'd0;
    if (!flt) begin
      mem_q.push_back({st, a[AW+1:2], exp_be, st ? exp_wdata : 32'd0});
      w_q.push_back(w);
      r_q.push_back(r);
      if (st) model_store(f, a, d);
      else exp_data = model_load(f, a);
    end
    req_valid = 1'b1;
    req_store = st;
    req_func_3 = f;
    req_address = a;
    req_store_data = d;
    #1;
    check("stall_on_accept", 64'(stall), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = flt ? 0 : (st ? 1 + w : 2 + w + r);
    exp_q.push_back({flt, exp_data, 32'(cyc + lat)});
  endtask

  // ---------------- memory responder ----------------
  logic resp_en = 1'b0;

  task automatic serve();
    logic [48:0] e;
    int w, r;
    logic [2:0] idx;
    if (mem_q.size() == 0) begin
      check("mem_valid_unexpected", 64'(mem_valid), 64'd0);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      return;
    end
    e = mem_q.pop_front();
    w = w_q.pop_front();
    r = r_q.pop_front();
    idx = mem_address[2:0];
    for (int i = 0; i <= w; i++) begin
      check("mem_valid_held", 64'(mem_valid), 64'd1);
      check("mem_write", 64'(mem_write), 64'(e[48]));
      check("mem_address", 64'(mem_address), 64'(e[47:36]));
      check("mem_byte_enable", 64'(mem_byte_enable), 64'(e[35:32]));
      if (e[48]) check("mem_write_data", 64'(mem_write_data), 64'(e[31:0]));
      check("stall_in_req", 64'(stall), 64'd1);
      mem_rvalid = 1'($urandom_range(0, 1));  // must be ignored here
      mem_read_data = $urandom;
      if (i < w) begin
        mem_ready = 1'b0;
      end else begin
        mem_ready = 1'b1;
        idx = mem_address[2:0];
        if (mem_write)
          for (int k = 0; k < 4; k++)
            if (mem_byte_enable[k]) mem_words[idx][8 * k +: 8] = mem_write_data[8 * k +: 8];
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    check("mem_valid_drop", 64'(mem_valid), 64'd0);
    if (!e[48]) begin
      for (int j = 0; j < r; j++) begin
        check("stall_in_wait", 64'(stall), 64'd1);
        mem_ready = 1'($urandom_range(0, 1));  // must be ignored here
        mem_read_data = $urandom;
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      mem_read_data = mem_words[idx];
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_ready = 1'b0;
    end
  endtask

  initial begin
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_read_data = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && rst_n && mem_valid) serve();
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_valid_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("rsp_fault", 64'(rsp_fault), 64'(e[64]));
          check("rsp_load_data", 64'(rsp_load_data), 64'(e[63:32]));
          check("rsp_cycle", 64'(cyc), 64'(e[31:0]));
          check("stall_in_resp", 64'(stall), 64'd0);
        end
      end else begin
        check("rsp_fault_idle", 64'(rsp_fault), 64'd0);
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0] f;
    logic st;
    int sz;

    req_valid = 1'b0;
    req_store = 1'b0;
    req_func_3 = 3'd0;
    req_address = 32'd0;
    req_store_data = 32'd0;
    for (int i = 0; i < 8; i++) begin
      mem_words[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_bytes[4 * i + k] = mem_words[i][8 * k +: 8];
    end

    // Reset state
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_mem_valid", 64'(mem_valid), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_mem_be", 64'(mem_byte_enable), 64'd0);
    check("reset_rsp_data", 64'(rsp_load_data), 64'd0);
    #11;
    rst_n = 1'b1;
    resp_en = 1'b1;
    @(posedge clk); #1;

    // Directed: stores, lane loads, faults, long waits
    do_req(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0);
    do_req(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 0, 0);
    do_req(1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 0, 0);
    do_req(1'b1, 3'b010, 32'h0000_0000, 32'h80FF_0000, 0, 0);
    do_req(1'b0, 3'b000, 32'h0000_0003, 32'd0, 0, 0);
    do_req(1'b0, 3'b100, 32'h0000_0003, 32'd0, 0, 0);
    do_req(1'b0, 3'b001, 32'h0000_0002, 32'd0, 0, 0);
    do_req(1'b0, 3'b101, 32'h0000_0002, 32'd0, 0, 0);
    do_req(1'b0, 3'b010, 32'h0000_0002, 32'd0, 0, 0);
    do_req(1'b0, 3'b001, 32'h0000_0001, 32'd0, 0, 0);
    do_req(1'b0, 3'b011, 32'h0000_0000, 32'd0, 0, 0);
    do_req(1'b1, 3'b100, 32'h0000_0000, 32'd0, 0, 0);
    do_req(1'b0, 3'b010, 32'h0000_0000, 32'd0, 3, 2);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      sz = size_of(f);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 4) a[1:0] = 2'b00;
        else if (sz == 2) a[0] = 1'b0;
      end
      do_req(st, f, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    // Reset while waiting for load data
    resp_en = 1'b0;
    req_valid = 1'b1;
    req_store = 1'b0;
    req_func_3 = 3'b010;
    req_address = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_test_mem_valid", 64'(mem_valid), 64'd1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("rst_test_stall_wait", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mid_stall", 64'(stall), 64'd0);
    check("rst_mid_req_ready", 64'(req_ready), 64'd1);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    mem_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_after_req_ready", 64'(req_ready), 64'd1);
    check("rst_after_mem_valid", 64'(mem_valid), 64'd0);

    // Normal operation resumes after reset
    resp_en = 1'b1;
    do_req(1'b0, 3'b000, 32'h0000_0013, 32'd0, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
